// File: rtl/cla_seq_adder_ctrl_if.sv
// cla_seq_adder_ctrl_if: operand and result handshake bundle for the sequential CLA adder
interface cla_seq_adder_ctrl_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/cla_seq_adder_ctrl.sv
// cla_seq_adder_ctrl: WIDTH-bit adder that reuses one SLICE-bit carry-lookahead slice per cycle
module cla_seq_adder_ctrl #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input logic               clk,
  input logic               rst_n,
  cla_seq_adder_ctrl_if.slave bus
);
  localparam int NS = WIDTH / SLICE;
  localparam int IW = NS > 1 ? $clog2(NS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state;
  state_t           w_next;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [SLICE-1:0] w_a_sl;
  logic [SLICE-1:0] w_b_sl;
  logic [SLICE-1:0] w_p;
  logic [SLICE-1:0] w_g;
  logic [SLICE-1:0] w_s;
  logic [SLICE:0]   w_c;
  logic             w_accept;
  logic             w_release;
  logic             w_last;

  if (WIDTH % SLICE != 0) begin : g_bad_slice
    $error("cla_seq_adder_ctrl: WIDTH must be a multiple of SLICE");
  end

  assign w_a_sl    = r_a[r_idx*SLICE +: SLICE];
  assign w_b_sl    = r_b[r_idx*SLICE +: SLICE];
  assign w_p       = w_a_sl ^ w_b_sl;
  assign w_g       = w_a_sl & w_b_sl;
  assign w_s       = w_p ^ w_c[SLICE-1:0];
  assign w_last    = r_idx == IW'(NS - 1);
  assign w_accept  = r_state == IDLE && bus.in_valid;
  assign w_release = r_state == DONE && bus.out_ready;

  assign bus.in_ready  = r_state == IDLE;
  assign bus.out_valid = r_state == DONE;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

  // Lookahead carries: each c[i+1] is a flat sum of products over g/p and the slice carry-in,
  // so no carry depends on the previous bit's carry net.
  always_comb begin
    logic v_term;
    logic v_prop;
    w_c    = '0;
    v_term = 1'b0;
    v_prop = 1'b1;
    w_c[0] = r_carry;
    for (int i = 0; i < SLICE; i++) begin
      v_term = 1'b0;
      v_prop = 1'b1;
      for (int j = i; j >= 0; j--) begin
        v_term = v_term | (v_prop & w_g[j]);
        v_prop = v_prop & w_p[j];
      end
      w_c[i+1] = v_term | (v_prop & r_carry);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    r_state <= !rst_n ? IDLE : w_next;
  end

  // Next state: accept in IDLE, step through slices in RUN, hand off the result in DONE
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? RUN : IDLE;
      RUN:     w_next = w_last ? DONE : RUN;
      DONE:    w_next = w_release ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, then fold one slice per RUN cycle into the sum
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_carry <= bus.cin;
      r_sum   <= '0;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_sum[r_idx*SLICE +: SLICE] <= w_s;
      r_carry <= w_c[SLICE];
      r_idx   <= r_idx + IW'(1);
      if (w_last) begin
        r_cout <= w_c[SLICE];
        r_ovf  <= w_c[SLICE] ^ w_c[SLICE-1];
      end
    end
  end
endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// tb_cla_seq_adder_ctrl: randomized and directed checks of the sequential CLA adder against an arithmetic model
module tb_cla_seq_adder_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  cla_seq_adder_ctrl_if #(.WIDTH(64)) bus ();

  cla_seq_adder_ctrl #(.WIDTH(64), .SLICE(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, failures=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b, input logic c);
    logic [64:0] f;
    logic        v;
    f = {1'b0, a} + {1'b0, b} + {64'd0, c};
    v = (a[63] == b[63]) && (f[63] != a[63]);
    return {f[63:0], f[64], v};
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0:       return 64'hFFFF_FFFF_FFFF_FFFF;
      1:       return 64'h8000_0000_0000_0000;
      2:       return 64'h7FFF_FFFF_FFFF_FFFF;
      3:       return 64'd0;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic c);
    bus.a = a;
    bus.b = b;
    bus.cin = c;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      bus.a = {$urandom, $urandom};
      bus.b = {$urandom, $urandom};
      bus.cin = 1'($urandom);
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic release_op();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_checks++;
    if ({bus.sum, bus.cout, bus.ovf} !== 66'd0) begin
      n_fail++; $display("FAIL reset_result got=%h/%b/%b exp=0/0/0", bus.sum, bus.cout, bus.ovf);
    end
  endtask

  task automatic test_directed();
    logic [63:0] ta [5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hAAAA_AAAA_AAAA_AAAA, 64'h7FFF_FFFF_FFFF_FFFF,
                            64'h8000_0000_0000_0000, 64'h1234_5678_9ABC_DEF0};
    logic [63:0] tb_ [5] = '{64'h0, 64'h5555_5555_5555_5555, 64'h1, 64'h8000_0000_0000_0000,
                            64'h0FED_CBA9_8765_4321};
    logic        tc [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [65:0] te [5] = '{{64'h0, 1'b1, 1'b0}, {64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0},
                            {64'h8000_0000_0000_0000, 1'b0, 1'b1}, {64'h0, 1'b1, 1'b1},
                            {64'h2222_2222_2222_2211, 1'b0, 1'b0}};
    int cyc;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL dir%0d_in_ready got=%b exp=1", i, bus.in_ready); end
      start_op(ta[i], tb_[i], tc[i]);
      wait_done(cyc);
      n_checks++;
      if (cyc !== 4) begin n_fail++; $display("FAIL dir%0d_latency got=%0d exp=4", i, cyc); end
      n_checks++;
      if ({bus.sum, bus.cout, bus.ovf} !== te[i]) begin
        n_fail++;
        $display("FAIL dir%0d_result got=%h/%b/%b exp=%h/%b/%b", i, bus.sum, bus.cout, bus.ovf,
                 te[i][65:2], te[i][1], te[i][0]);
      end
      release_op();
      n_checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
        n_fail++; $display("FAIL dir%0d_release got valid/ready=%b%b exp=01", i, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] a;
    logic [63:0] b;
    logic        c;
    logic [65:0] e;
    int          cyc;
    for (int i = 0; i < 40; i++) begin
      a = pick();
      b = pick();
      c = 1'($urandom);
      e = model(a, b, c);
      start_op(a, b, c);
      wait_done(cyc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      n_checks++;
      if (cyc !== 4 || {bus.sum, bus.cout, bus.ovf} !== e) begin
        n_fail++;
        $display("FAIL rand%0d a=%h b=%h cin=%b got=%h/%b/%b lat=%0d exp=%h/%b/%b lat=4", i, a, b, c,
                 bus.sum, bus.cout, bus.ovf, cyc, e[65:2], e[1], e[0]);
      end
      release_op();
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a2 = 64'hDEAD_BEEF_0123_4567;
    logic [63:0] b2 = 64'h8765_4321_FEDC_BA98;
    logic [65:0] e1 = model(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b1);
    logic [65:0] e2 = model(a2, b2, 1'b1);
    int cyc;
    start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b1);
    wait_done(cyc);
    bus.a = a2;
    bus.b = b2;
    bus.cin = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || {bus.sum, bus.cout, bus.ovf} !== e1) begin
        n_fail++;
        $display("FAIL hold%0d got valid=%b ready=%b res=%h/%b/%b exp valid=1 ready=0 res=%h/%b/%b", i,
                 bus.out_valid, bus.in_ready, bus.sum, bus.cout, bus.ovf, e1[65:2], e1[1], e1[0]);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL b2b_release got valid/ready=%b%b exp=01", bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_accept got in_ready=%b exp=0", bus.in_ready); end
    wait_done(cyc);
    n_checks++;
    if (cyc !== 4 || {bus.sum, bus.cout, bus.ovf} !== e2) begin
      n_fail++;
      $display("FAIL b2b_result got=%h/%b/%b lat=%0d exp=%h/%b/%b lat=4", bus.sum, bus.cout, bus.ovf, cyc,
               e2[65:2], e2[1], e2[0]);
    end
    release_op();
  endtask

  task automatic test_mid_reset();
    int cyc;
    start_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    wait_done(cyc);
    release_op();
    start_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_hs got ready=%b valid=%b exp ready=1 valid=0", bus.in_ready, bus.out_valid);
    end
    n_checks++;
    if ({bus.sum, bus.cout, bus.ovf} !== 66'd0) begin
      n_fail++; $display("FAIL midrst_result got=%h/%b/%b exp=0/0/0", bus.sum, bus.cout, bus.ovf);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_pulse%0d got out_valid=%b exp=0", i, bus.out_valid); end
    end
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    wait_done(cyc);
    n_checks++;
    if (cyc !== 4 || {bus.sum, bus.cout, bus.ovf} !== {64'h0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL midrst_rerun got=%h/%b/%b lat=%0d exp=0/1/0 lat=4", bus.sum, bus.cout, bus.ovf, cyc);
    end
    release_op();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
